arbitro_codificador: RTL and testbench
======================================

ARBITRO_CODIFICADOR -- requirements
Module: arbitro_codificador

Interface
REQ-001 Parameter: ENC_LAT, default 2, number of clock cycles the codificador output needs after the ready pulse before m1..m5 is valid; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0  input  1  requester 0 wants one nibble encoded; held until ack0.
REQ-005 dat0  input  4  requester 0 nibble; dat0[3] maps to a, dat0[0] maps to d.
REQ-006 ack0  output  1  one-cycle grant/accept for requester 0.
REQ-007 req1, dat1, ack1  input/input/output  1/4/1  requester 1 equivalents of REQ-004..006.
REQ-008 a, b, c, d  output  1 each  encoder data inputs.
REQ-009 ready  output  1  encoder strobe.
REQ-010 m_in  input  5  encoder result, m_in[4]=m1 ... m_in[0]=m5.
REQ-011 out_valid  output  1  one-cycle result strobe.
REQ-012 out_code  output  5  captured encoder result.
REQ-013 out_src  output  1  requester that owns out_code (0/1).
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, DRIVE, WAIT, DONE; no other reachable state.
REQ-016 IDLE: if req0 or req1 sampled high at a rising edge, block SHALL grant one, latch its dat into {a,b,c,d}, record src, load wait counter with ENC_LAT, enter DRIVE; else stay IDLE.
REQ-017 Arbitration SHALL be round-robin: single requester always wins; with both high, winner is the requester not served last; after reset, requester 0 has priority.
REQ-018 DRIVE lasts exactly one cycle: ready=1 and ack of granted requester=1 during it, then WAIT.
REQ-019 ready and ack0/ack1 SHALL be 0 in every state other than DRIVE; ack0 and ack1 never both high.
REQ-020 WAIT lasts exactly ENC_LAT cycles; on the last WAIT edge, out_code<=m_in, out_src<=recorded src, enter DONE.
REQ-021 DONE lasts one cycle with out_valid=1, then IDLE unconditionally.
REQ-022 Latency: req sampled at edge E0 -> DRIVE in cycle 1, out_valid in cycle ENC_LAT+2; minimum spacing between grants is ENC_LAT+3 cycles.
REQ-023 a..d SHALL stay constant from the grant edge until the next grant; out_code/out_src hold until next DONE.
REQ-024 dat is sampled only at the grant edge; changes on dat afterwards have no effect.
REQ-025 req dropped before grant withdraws the request with no side effect; req still high in cycle after ack counts as a new request.
REQ-026 m_in SHALL be sampled only on the final WAIT edge; values at other times ignored.

Reset
REQ-027 reset=1 SHALL force, asynchronously: state IDLE, a,b,c,d,ready,ack0,ack1,out_valid,busy,out_src=0, out_code=5'b00000, counter 0, round-robin priority to requester 0.
REQ-028 reset during DRIVE/WAIT/DONE SHALL abort the transaction: no out_valid for it, result discarded, requester must re-request.

Verification (ENC_LAT=2 unless stated)
REQ-029 Release reset, no requests for 10 cycles -> every output stays 0, busy=0.
REQ-030 req0=1, dat0=4'b1010, m_in=5'b10110 held -> cycle 1: ack0=1, ready=1, a,b,c,d=1,0,1,0; cycle 4: out_valid=1, out_code=10110, out_src=0.
REQ-031 req0 and req1 both raised at same edge after reset, dropped on ack -> ack0 first, then ack1 exactly 5 cycles later; out_src sequence 0,1.
REQ-032 req0 and req1 held high continuously -> grants alternate 0,1,0,1; no two consecutive grants to same requester.
REQ-033 reset pulsed during WAIT -> all outputs 0 immediately, no out_valid; req1 held high then granted in first IDLE cycle after release.
REQ-034 ENC_LAT=1 build, single req1, dat1=4'b0111, m_in=5'b01001 -> out_valid in cycle 3, out_code=01001, out_src=1, ack0 never high.

Source files
------------

// File: rtl/arbitro_codificador.sv
// Round-robin arbiter that feeds one of two requesters' nibbles to an external
// encoder, waits ENC_LAT cycles for its result and presents it with the owner's id.
module arbitro_codificador #(
    parameter int unsigned ENC_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [3:0] dat0,
    output logic       ack0,
    input  logic       req1,
    input  logic [3:0] dat1,
    output logic       ack1,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       ready,
    input  logic [4:0] m_in,
    output logic       out_valid,
    output logic [4:0] out_code,
    output logic       out_src,
    output logic       busy
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned CODE_W = 5;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              prio, prio_nxt;      // requester favoured on a tie
    logic              src, src_nxt;
    logic              win;
    logic [NIB_W-1:0]  nib, nib_nxt;
    logic [CODE_W-1:0] code_nxt;
    logic              out_src_nxt;
    logic              ack0_nxt, ack1_nxt, ready_nxt, valid_nxt, busy_nxt;

    // Next-state and next-output decode
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        prio_nxt    = prio;
        src_nxt     = src;
        win         = 1'b0;
        nib_nxt     = nib;
        code_nxt    = out_code;
        out_src_nxt = out_src;
        ack0_nxt    = 1'b0;
        ack1_nxt    = 1'b0;
        ready_nxt   = 1'b0;
        valid_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    win       = (req0 && req1) ? prio : req1;
                    src_nxt   = win;
                    nib_nxt   = win ? dat1 : dat0;
                    cnt_nxt   = CNT_W'(ENC_LAT);
                    prio_nxt  = ~win;
                    ack0_nxt  = ~win;
                    ack1_nxt  = win;
                    ready_nxt = 1'b1;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                // m_in is only trusted on the last wait edge
                if (cnt <= CNT_W'(1)) begin
                    code_nxt    = m_in;
                    out_src_nxt = src;
                    valid_nxt   = 1'b1;
                    cnt_nxt     = '0;
                    state_nxt   = DONE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            prio      <= 1'b0;
            src       <= 1'b0;
            nib       <= '0;
            out_code  <= '0;
            out_src   <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            ready     <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            prio      <= prio_nxt;
            src       <= src_nxt;
            nib       <= nib_nxt;
            out_code  <= code_nxt;
            out_src   <= out_src_nxt;
            ack0      <= ack0_nxt;
            ack1      <= ack1_nxt;
            ready     <= ready_nxt;
            out_valid <= valid_nxt;
            busy      <= busy_nxt;
        end
    end

    assign a = nib[3];
    assign b = nib[2];
    assign c = nib[1];
    assign d = nib[0];

    // Protocol invariants of the registered handshake outputs
    a_ack_excl: assert property (@(posedge clk) disable iff (reset) !(ack0 && ack1));
    a_ready_ack: assert property (@(posedge clk) disable iff (reset) ready == (ack0 || ack1));
    a_valid_pulse: assert property (@(posedge clk) disable iff (reset) out_valid |=> !out_valid);

endmodule

// File: tb/tb_arbitro_codificador.sv
// Self-checking bench for arbitro_codificador: directed scenarios plus a
// randomized run against a transaction-level timing model.
module tb_arbitro_codificador;

    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [3:0] dat0 = '0, dat1 = '0;
    logic [4:0] m_in = '0;

    logic       ack0, ack1, a, b, c, d, ready, out_valid, out_src, busy;
    logic [4:0] out_code;
    logic       ack0_l1, ack1_l1, a_l1, b_l1, c_l1, d_l1, ready_l1, out_valid_l1, out_src_l1, busy_l1;
    logic [4:0] out_code_l1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    arbitro_codificador #(.ENC_LAT(2)) u_dut (
        .clk(clk), .reset(reset),
        .req0(req0), .dat0(dat0), .ack0(ack0),
        .req1(req1), .dat1(dat1), .ack1(ack1),
        .a(a), .b(b), .c(c), .d(d), .ready(ready), .m_in(m_in),
        .out_valid(out_valid), .out_code(out_code), .out_src(out_src), .busy(busy)
    );

    arbitro_codificador #(.ENC_LAT(1)) u_dut_l1 (
        .clk(clk), .reset(reset),
        .req0(req0), .dat0(dat0), .ack0(ack0_l1),
        .req1(req1), .dat1(dat1), .ack1(ack1_l1),
        .a(a_l1), .b(b_l1), .c(c_l1), .d(d_l1), .ready(ready_l1), .m_in(m_in),
        .out_valid(out_valid_l1), .out_code(out_code_l1), .out_src(out_src_l1), .busy(busy_l1)
    );

    // {ack0,ack1,ready,busy,out_valid,a,b,c,d,out_code,out_src}
    function automatic logic [14:0] outs();
        return {ack0, ack1, ready, busy, out_valid, a, b, c, d, out_code, out_src};
    endfunction

    function automatic logic [14:0] outs_l1();
        return {ack0_l1, ack1_l1, ready_l1, busy_l1, out_valid_l1,
                a_l1, b_l1, c_l1, d_l1, out_code_l1, out_src_l1};
    endfunction

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; dat0 = '0; dat1 = '0; m_in = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (outs() !== 15'd0 || outs_l1() !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_async: got %h / %h, want 0", outs(), outs_l1());
        end
        @(negedge clk);
        reset = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            n_checks++;
            if (outs() !== 15'd0 || outs_l1() !== 15'd0) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: got %h / %h, want 0", n, outs(), outs_l1());
            end
        end
    endtask

    task automatic test_single();
        logic [14:0] exp;
        logic [4:0]  e_code;
        reset_dut();
        req0 = 1'b1; dat0 = 4'b1010; m_in = 5'b10110;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            e_code = (n >= 4) ? 5'b10110 : 5'b00000;
            exp = {n == 1, 1'b0, n == 1, n <= 4, n == 4, 4'b1010, e_code, 1'b0};
            n_checks++;
            if (outs() !== exp) begin
                n_fail++;
                $display("FAIL single cycle %0d: got %h, want %h", n, outs(), exp);
            end
            if (n == 1) begin
                req0 = 1'b0;
                dat0 = 4'b0101;
            end
            if (n == 4) m_in = 5'b00001;
        end
    endtask

    task automatic test_both();
        int ack0_cyc, ack1_cyc, nv;
        logic [1:0] srcs;
        ack0_cyc = -1; ack1_cyc = -1; nv = 0; srcs = '0;
        reset_dut();
        req0 = 1'b1; req1 = 1'b1; dat0 = 4'h3; dat1 = 4'hC; m_in = 5'h15;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (ack0 && ack0_cyc < 0) begin ack0_cyc = n; req0 = 1'b0; end
            if (ack1 && ack1_cyc < 0) begin ack1_cyc = n; req1 = 1'b0; end
            if (out_valid) begin
                if (nv < 2) srcs[nv] = out_src;
                nv++;
            end
        end
        n_checks++;
        if (ack0_cyc != 1) begin
            n_fail++;
            $display("FAIL both_ack0: got cycle %0d, want 1", ack0_cyc);
        end
        n_checks++;
        if (ack1_cyc != 6) begin
            n_fail++;
            $display("FAIL both_ack1: got cycle %0d, want 6", ack1_cyc);
        end
        n_checks++;
        if (nv != 2 || srcs !== 2'b10) begin
            n_fail++;
            $display("FAIL both_src_seq: got %0d results srcs[1:0]=%b, want 2 results 10", nv, srcs);
        end
    endtask

    task automatic test_alternate();
        int cnt, last_cyc;
        logic last_src;
        cnt = 0; last_cyc = 0; last_src = 1'b1;
        reset_dut();
        req0 = 1'b1; req1 = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            dat0 = 4'($urandom); dat1 = 4'($urandom); m_in = 5'($urandom);
            n_checks++;
            if (ack0 && ack1) begin
                n_fail++;
                $display("FAIL alt_excl cycle %0d: got both acks high, want at most one", n);
            end
            if (ack0 || ack1) begin
                n_checks++;
                if (ack1 !== ~last_src || (n - last_cyc) != (cnt == 0 ? 1 : LAT + 3)) begin
                    n_fail++;
                    $display("FAIL alt_grant cycle %0d: got src %0d gap %0d, want src %0d gap %0d",
                             n, ack1, n - last_cyc, ~last_src, (cnt == 0 ? 1 : LAT + 3));
                end
                last_src = ack1; last_cyc = n; cnt++;
            end
        end
        n_checks++;
        if (cnt != 8) begin
            n_fail++;
            $display("FAIL alt_count: got %0d grants, want 8", cnt);
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_reset_wait();
        reset_dut();
        req1 = 1'b1; dat1 = 4'b0011; m_in = 5'b00111;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (outs() !== 15'd0) begin
            n_fail++;
            $display("FAIL rst_wait_async: got %h, want 0", outs());
        end
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            n_checks++;
            if (outs() !== 15'd0) begin
                n_fail++;
                $display("FAIL rst_wait_hold %0d: got %h, want 0", n, outs());
            end
        end
        reset = 1'b0;
        m_in = 5'b11100;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            if (n == 1) begin
                n_checks++;
                if (ack1 !== 1'b1 || ack0 !== 1'b0 || {a, b, c, d} !== 4'b0011) begin
                    n_fail++;
                    $display("FAIL rst_regrant: got ack0=%b ack1=%b abcd=%b, want 0 1 0011",
                             ack0, ack1, {a, b, c, d});
                end
                req1 = 1'b0;
            end
            n_checks++;
            if (out_valid !== (n == 4)) begin
                n_fail++;
                $display("FAIL rst_valid cycle %0d: got %b, want %b", n, out_valid, n == 4);
            end
            if (n == 4) begin
                n_checks++;
                if (out_code !== 5'b11100 || out_src !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rst_result: got %b/%b, want 11100/1", out_code, out_src);
                end
            end
        end
    endtask

    task automatic test_enc_lat1();
        reset_dut();
        req1 = 1'b1; dat1 = 4'b0111; m_in = 5'b01001;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            if (n == 1) begin
                n_checks++;
                if (ack1_l1 !== 1'b1 || ready_l1 !== 1'b1 || {a_l1, b_l1, c_l1, d_l1} !== 4'b0111) begin
                    n_fail++;
                    $display("FAIL l1_grant: got ack1=%b ready=%b abcd=%b, want 1 1 0111",
                             ack1_l1, ready_l1, {a_l1, b_l1, c_l1, d_l1});
                end
                req1 = 1'b0;
            end
            n_checks++;
            if (ack0_l1 !== 1'b0 || out_valid_l1 !== (n == 3)) begin
                n_fail++;
                $display("FAIL l1_cycle %0d: got ack0=%b valid=%b, want 0 %b", n, ack0_l1, out_valid_l1, n == 3);
            end
            if (n == 3) begin
                n_checks++;
                if (out_code_l1 !== 5'b01001 || out_src_l1 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL l1_result: got %b/%b, want 01001/1", out_code_l1, out_src_l1);
                end
            end
        end
    endtask

    // Transaction model: a grant at edge g gives ack/ready after g, captures m_in
    // at edge g+LAT+1 (out_valid after it) and allows the next grant at g+LAT+3.
    task automatic test_random();
        int g, free_edge;
        logic last_served, m_src, m_osrc, w, e_busy;
        logic [3:0]  m_dat;
        logic [4:0]  m_code;
        logic [14:0] exp;
        g = -1000; free_edge = 0; last_served = 1'b1;
        m_src = 1'b0; m_osrc = 1'b0; m_dat = '0; m_code = '0;
        reset_dut();
        req0 = ($urandom_range(0, 2) != 0); req1 = ($urandom_range(0, 2) != 0);
        dat0 = 4'($urandom); dat1 = 4'($urandom); m_in = 5'($urandom);
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (k >= free_edge && (req0 || req1)) begin
                w = (req0 && req1) ? ~last_served : req1;
                g = k; m_src = w; m_dat = w ? dat1 : dat0;
                last_served = w;
                free_edge = k + LAT + 3;
            end
            if (k == g + LAT + 1) begin
                m_code = m_in; m_osrc = m_src;
            end
            e_busy = (k >= g) && (k <= g + LAT + 1);
            exp = {(k == g) && !m_src, (k == g) && m_src, k == g, e_busy,
                   k == g + LAT + 1, m_dat, m_code, m_osrc};
            n_checks++;
            if (outs() !== exp) begin
                n_fail++;
                $display("FAIL random edge %0d: got %h, want %h", k, outs(), exp);
            end
            req0 = ($urandom_range(0, 2) != 0); req1 = ($urandom_range(0, 2) != 0);
            dat0 = 4'($urandom); dat1 = 4'($urandom); m_in = 5'($urandom);
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_both();
        test_alternate();
        test_reset_wait();
        test_enc_lat1();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
